// File: rtl/rr_req_stage_pkg.sv
// Shared sizing and slot-state definitions for the round-robin request stage.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package rr_req_stage_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = $clog2(ARB_N);

  typedef logic [ARB_N-1:0]     arb_vec_t;
  typedef logic [ARB_IDX_W-1:0] arb_idx_t;

  // Output slot occupancy; FULL is exactly gnt_valid.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/rr_req_stage_onehot_enc.sv
// One-hot to binary encoder with "any" and "more than one bit set" flags.
// Latency: purely combinational.
// Backpressure: none; output follows input every cycle.
module onehot_enc #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // OR together the indices of set bits; multi flags a second set bit.
  always_comb begin
    idx   = '0;
    any   = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) begin
        multi = multi | any;
        any   = 1'b1;
        idx   = idx | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_req_stage.sv
// Collects sticky requests for the pselect tree and registers its grant into a valid/ready slot.
// Latency: req_in -> pending 1 cycle -> gnt_valid 1 more cycle; one grant per cycle sustained.
// Backpressure: gnt_ready low with a full slot drops tree_en; slot, tree_sel and pending hold.
module rr_req_stage
  import rr_req_stage_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req_in,
  output logic [N-1:0]     tree_req,
  output logic             tree_en,
  output logic [IDX_W-1:0] tree_sel,
  input  logic [N-1:0]     tree_gnt,
  output logic             gnt_valid,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  input  logic             gnt_ready,
  output logic [N-1:0]     pending,
  output logic             err
);

  slot_state_e      slot_q;
  logic [N-1:0]     pending_q;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             enc_multi;
  logic             gnt_foreign;
  logic             gnt_missing;
  logic             proto_err;
  logic             load;
  logic [N-1:0]     gnt_clr;

  onehot_enc #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc (
    .onehot (tree_gnt),
    .idx    (enc_idx),
    .any    (enc_any),
    .multi  (enc_multi)
  );

  assign gnt_valid = (slot_q == SLOT_FULL);
  assign tree_en   = !gnt_valid || gnt_ready;
  assign tree_req  = pending_q;
  assign pending   = pending_q;

  // A grant must be at most one-hot, only to a pending requester, and present whenever anything is pending.
  assign gnt_foreign = |(tree_gnt & ~pending_q);
  assign gnt_missing = (|pending_q) && !enc_any;
  assign proto_err   = tree_en && (enc_multi || gnt_foreign || gnt_missing);
  assign load        = tree_en && enc_any && !proto_err;
  assign gnt_clr     = load ? tree_gnt : '0;

  // Sticky pending bits: clear the granted bit, then OR in new requests (a same-cycle re-request wins).
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~gnt_clr) | req_in;
    end
  end

  // Output slot FSM; a load also rotates tree_sel away from the granted path at every level.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q     <= SLOT_EMPTY;
      gnt_onehot <= '0;
      gnt_idx    <= '0;
      tree_sel   <= '0;
    end else begin
      if (load) begin
        gnt_onehot <= tree_gnt;
        gnt_idx    <= enc_idx;
        tree_sel   <= ~enc_idx;
      end
      case (slot_q)
        SLOT_EMPTY: if (load) slot_q <= SLOT_FULL;
        SLOT_FULL:  if (gnt_ready && !load) slot_q <= SLOT_EMPTY;
        default:    slot_q <= SLOT_EMPTY;
      endcase
    end
  end

  // Protocol error latches until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (proto_err) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_req_stage.sv
// Directed bench for rr_req_stage with a behavioural pselect tree and a grant scoreboard.
// Latency: checks at #1 after posedge (main) and at negedge (monitor).
// Backpressure: gnt_ready is driven directly by the stimulus.
module tb_rr_req_stage;
  import rr_req_stage_pkg::*;

  localparam int N     = ARB_N;
  localparam int IDX_W = ARB_IDX_W;

  typedef struct {
    arb_vec_t oh;
    arb_idx_t idx;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  arb_vec_t   req_in;
  arb_vec_t   tree_req;
  logic       tree_en;
  arb_idx_t   tree_sel;
  arb_vec_t   tree_gnt;
  logic       gnt_valid;
  arb_vec_t   gnt_onehot;
  arb_idx_t   gnt_idx;
  logic       gnt_ready;
  arb_vec_t   pending;
  logic       err;

  logic       inj_en;
  arb_vec_t   inj_val;

  int         n_checks = 0;
  int         n_fail   = 0;
  exp_t       sb_q[$];

  always #5 clock = ~clock;

  rr_req_stage #(.N(N), .IDX_W(IDX_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_in     (req_in),
    .tree_req   (tree_req),
    .tree_en    (tree_en),
    .tree_sel   (tree_sel),
    .tree_gnt   (tree_gnt),
    .gnt_valid  (gnt_valid),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_ready  (gnt_ready),
    .pending    (pending),
    .err        (err)
  );

  // Behavioural tree: per level, sel bit 1 favours the upper half, 0 the lower half.
  function automatic arb_vec_t tree_pick(input arb_vec_t req, input arb_idx_t sel);
    int       lo;
    int       size;
    int       half;
    logic     up_any;
    logic     lo_any;
    arb_vec_t g;
    lo   = 0;
    size = N;
    g    = '0;
    if (req != '0) begin
      for (int l = IDX_W - 1; l >= 0; l--) begin
        half   = size / 2;
        up_any = 1'b0;
        lo_any = 1'b0;
        for (int b = 0; b < N; b++) begin
          if (b >= lo && b < lo + half && req[b]) lo_any = 1'b1;
          if (b >= lo + half && b < lo + size && req[b]) up_any = 1'b1;
        end
        if ((sel[l] && up_any) || !lo_any) lo = lo + half;
        size = half;
      end
      g[lo] = 1'b1;
    end
    return g;
  endfunction

  always_comb begin
    tree_gnt = '0;
    if (inj_en) tree_gnt = inj_val;
    else if (tree_en) tree_gnt = tree_pick(tree_req, tree_sel);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int idx);
    exp_t e;
    e.oh      = '0;
    e.oh[idx] = 1'b1;
    e.idx     = IDX_W'(idx);
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every accepted slot must match the next expected grant.
  always @(negedge clock) begin
    if (!reset && gnt_valid && gnt_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_grant", 32'(gnt_onehot), 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_onehot", 32'(gnt_onehot), 32'(e.oh));
        check("sb_idx", 32'(gnt_idx), 32'(e.idx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_in    = '0;
    gnt_ready = 1'b1;
    inj_en    = 1'b0;
    inj_val   = '0;
    cyc();
    cyc();
    check("rst_valid", 32'(gnt_valid), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_sel", 32'(tree_sel), 0);
    check("rst_onehot", 32'(gnt_onehot), 0);
    check("rst_idx", 32'(gnt_idx), 0);
    check("rst_err", 32'(err), 0);

    // 1: single request, two-cycle latency
    reset  = 1'b0;
    req_in = 8'h04;
    push_exp(2);
    cyc();
    check("t1_pending", 32'(pending), 32'h04);
    check("t1_valid_early", 32'(gnt_valid), 0);
    req_in = '0;
    cyc();
    check("t1_valid", 32'(gnt_valid), 1);
    check("t1_idx", 32'(gnt_idx), 2);
    check("t1_onehot", 32'(gnt_onehot), 32'h04);
    check("t1_sel", 32'(tree_sel), 32'h5);
    check("t1_pending_clr", 32'(pending), 0);
    cyc();
    check("t1_drain", 32'(gnt_valid), 0);

    // 2: all requesters, eight back-to-back grants in rotation order
    req_in = 8'hFF;
    push_exp(5); push_exp(2); push_exp(4); push_exp(3);
    push_exp(6); push_exp(1); push_exp(7); push_exp(0);
    cyc();
    req_in = '0;
    check("t2_pending", 32'(pending), 32'hFF);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("t2_valid", 32'(gnt_valid), 1);
    end
    cyc();
    check("t2_drain", 32'(gnt_valid), 0);
    check("t2_sel", 32'(tree_sel), 32'h7);
    check("t2_pending", 32'(pending), 0);
    check("t2_sb_empty", 32'(sb_q.size()), 0);

    // 3: stall with a full slot while new requests accumulate
    gnt_ready = 1'b0;
    req_in    = 8'h10;
    push_exp(4);
    cyc();
    req_in = 8'h81;
    cyc();
    for (int i = 0; i < 5; i++) begin
      check("t3_valid", 32'(gnt_valid), 1);
      check("t3_onehot", 32'(gnt_onehot), 32'h10);
      check("t3_tree_en", 32'(tree_en), 0);
      check("t3_pending", 32'(pending), 32'h81);
      check("t3_sel", 32'(tree_sel), 32'h3);
      cyc();
    end
    req_in    = '0;
    gnt_ready = 1'b1;
    push_exp(0);
    push_exp(7);
    cyc();
    check("t3_reload_valid", 32'(gnt_valid), 1);
    check("t3_reload_idx", 32'(gnt_idx), 0);
    check("t3_reload_sel", 32'(tree_sel), 32'h7);
    check("t3_reload_pending", 32'(pending), 32'h80);
    cyc();
    check("t3_last_idx", 32'(gnt_idx), 7);
    check("t3_last_sel", 32'(tree_sel), 0);
    cyc();
    check("t3_drain", 32'(gnt_valid), 0);

    // 4: re-request on the bit being granted
    req_in = 8'h08;
    push_exp(3);
    cyc();
    push_exp(3);
    cyc();
    req_in = '0;
    check("t4_pending_kept", 32'(pending), 32'h08);
    check("t4_idx", 32'(gnt_idx), 3);
    cyc();
    check("t4_regrant_valid", 32'(gnt_valid), 1);
    check("t4_regrant_idx", 32'(gnt_idx), 3);
    check("t4_pending_clr", 32'(pending), 0);
    cyc();
    check("t4_drain", 32'(gnt_valid), 0);
    check("t4_no_err", 32'(err), 0);

    // 5: multi-hot grant from the tree
    inj_en  = 1'b1;
    inj_val = 8'h0C;
    cyc();
    inj_en = 1'b0;
    check("t5_err", 32'(err), 1);
    check("t5_no_load", 32'(gnt_valid), 0);
    cyc();
    check("t5_err_sticky", 32'(err), 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t5_err_cleared", 32'(err), 0);

    // 6: reset with a full slot and pending work
    gnt_ready = 1'b0;
    req_in    = 8'h10;
    cyc();
    req_in = 8'h20;
    cyc();
    req_in = 8'h10;
    cyc();
    req_in = '0;
    check("t6_full", 32'(gnt_valid), 1);
    check("t6_pending", 32'(pending), 32'h30);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    gnt_ready = 1'b1;
    check("t6_valid", 32'(gnt_valid), 0);
    check("t6_pending_rst", 32'(pending), 0);
    check("t6_sel", 32'(tree_sel), 0);
    check("t6_onehot", 32'(gnt_onehot), 0);
    check("t6_idx", 32'(gnt_idx), 0);
    cyc();
    check("t6_idle", 32'(gnt_valid), 0);
    check("final_sb_empty", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
